// File: rtl/mult_acc_if.sv
// Handshake and result bundle for mult_acc_stage.
//   in_valid/in_ready/product/in_last : product stream into the accumulator
//   out_valid/out_ready               : frame result handshake
//   sum_out/terms_out/overrun         : frame result payload
interface mult_acc_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  product;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] sum_out;
  logic [4:0]  terms_out;
  logic        overrun;

  // Producer/consumer side (drives products, accepts results).
  modport master (
    output in_valid, product, in_last, out_ready,
    input  in_ready, out_valid, sum_out, terms_out, overrun
  );

  // Accumulator side.
  modport slave (
    input  in_valid, product, in_last, out_ready,
    output in_ready, out_valid, sum_out, terms_out, overrun
  );
endinterface

// File: rtl/mult_acc_stage.sv
// Frame accumulator for 4x4 multiplier products.
// Sums up to MAX_TERMS products per frame; a frame closes on in_last or when
// the term count reaches MAX_TERMS (flagged as overrun). The result is held
// in DONE until the downstream accepts it; frames never overlap.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mult_acc_if.slave (product input stream + result output)
module mult_acc_stage #(
  parameter int unsigned MAX_TERMS = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  mult_acc_if.slave     bus
);

  localparam int unsigned ACC_W  = 12;
  localparam int unsigned CNT_W  = 5;

  typedef enum logic {ST_ACC, ST_DONE} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   terms_q, terms_d;
  logic               ovr_q, ovr_d;

  logic [ACC_W-1:0]   acc_next;
  logic [CNT_W-1:0]   cnt_next;
  logic               close_frame;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      terms_q <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      terms_q <= terms_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    terms_d     = terms_q;
    ovr_d       = ovr_q;
    acc_next    = acc_q + ACC_W'(bus.product);
    cnt_next    = cnt_q + CNT_W'(1);
    close_frame = bus.in_last || (cnt_next == CNT_W'(MAX_TERMS));

    unique case (state_q)
      ST_ACC: begin
        if (bus.in_valid) begin
          if (close_frame) begin
            sum_d   = acc_next;
            terms_d = cnt_next;
            // in_last wins when it coincides with the term limit
            ovr_d   = !bus.in_last;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = ST_DONE;
          end else begin
            acc_d = acc_next;
            cnt_d = cnt_next;
          end
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_ACC;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  // Handshake outputs decode the state register only.
  assign bus.in_ready  = (state_q == ST_ACC);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.sum_out   = sum_q;
  assign bus.terms_out = terms_q;
  assign bus.overrun   = ovr_q;

endmodule

// File: doc/mult_acc_stage.md
MULT_ACC_STAGE -- requirements
Module: mult_acc_stage

Interface
REQ-001 The block SHALL have parameter MAX_TERMS, default 16, giving the maximum number of products per frame (legal range 1..16).
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  product word present on `product`.
REQ-005 in_ready  output  1  block can accept a product this cycle.
REQ-006 product  input  8  unsigned 4x4 multiplier result, 0..225.
REQ-007 in_last  input  1  marks the final product of the frame; sampled only on an accepted transfer.
REQ-008 out_valid  output  1  frame result present on sum_out/terms_out/overrun.
REQ-009 out_ready  input  1  downstream accepts the result.
REQ-010 sum_out  output  12  unsigned sum of all products in the frame.
REQ-011 terms_out  output  5  number of products in the frame, 1..MAX_TERMS.
REQ-012 overrun  output  1  frame was closed by MAX_TERMS, not by in_last.

Function
REQ-013 Input transfer SHALL occur only in a cycle with in_valid=1 and in_ready=1; output transfer only with out_valid=1 and out_ready=1.
REQ-014 The FSM SHALL have two states: ACC (in_ready=1, out_valid=0) and DONE (in_ready=0, out_valid=1).
REQ-015 In ACC, each transfer SHALL set acc <= acc + product and cnt <= cnt + 1, with acc a 12-bit and cnt a 5-bit internal register.
REQ-016 A transfer SHALL close the frame when in_last=1 or when cnt+1 equals MAX_TERMS, whichever applies first.
REQ-017 On frame close, the block SHALL in that same edge load sum_out <= acc + product, terms_out <= cnt + 1, overrun <= (in_last==0), clear acc and cnt to 0, and enter DONE.
REQ-018 Latency SHALL be one cycle: out_valid rises on the cycle after the closing transfer.
REQ-019 With in_last=1 on the transfer that reaches MAX_TERMS, overrun SHALL be 0.
REQ-020 In DONE, sum_out, terms_out and overrun SHALL be held stable until the output transfer.
REQ-021 On the output transfer, the block SHALL return to ACC so that in_ready=1 on the following cycle; there is no overlap of frames (no bypass from out_ready to in_ready).
REQ-022 In ACC, in_valid=0 cycles SHALL leave acc and cnt unchanged (gaps within a frame are legal).
REQ-023 The 12-bit sum SHALL never wrap, since 16 x 225 = 3600 < 4096. No saturation logic is required.
REQ-024 While in ACC, sum_out/terms_out/overrun SHALL retain the last delivered frame's values. They are don't-care for checking while out_valid=0.
REQ-025 in_ready and out_valid SHALL be decoded directly from the state register, with no combinational path from any input.

Reset
REQ-026 Assertion of rst_n=0 SHALL immediately force state=ACC, acc=0, cnt=0, sum_out=0, terms_out=0, overrun=0. This gives in_ready=1 and out_valid=0.
REQ-027 Reset mid-frame or in DONE SHALL discard the partial or pending result without emitting it.
REQ-028 After rst_n deasserts, the first rising edge SHALL be able to accept a transfer.

Verification
REQ-029 Single term: product=0x06 with in_last=1, out_ready=1 -> next cycle out_valid=1, sum_out=6, terms_out=1, overrun=0; then in_ready=1 one cycle later.
REQ-030 Full frame: 16 transfers of product=225, in_last only on the 16th -> sum_out=3600 (0xE10), terms_out=16, overrun=0.
REQ-031 Forced close: 17 transfers of product=1 with in_last=0 (MAX_TERMS=16) -> first result sum_out=16, terms_out=16, overrun=1. The 17th product begins a new frame with acc=1.
REQ-032 Backpressure: result pending with out_ready=0 for 5 cycles -> outputs stable and in_ready=0 throughout; released on the cycle out_ready=1.
REQ-033 Gaps: products 10, 20, 30 with 2-cycle in_valid gaps, in_last on 30 -> sum_out=60, terms_out=3.
REQ-034 Reset mid-frame: 3 products accepted, rst_n pulsed low asynchronously -> out_valid=0 and in_ready=1 immediately; the next frame (product=5, in_last=1) gives sum_out=5, terms_out=1.
